// File: rtl/ervp_mmio_wide_push.sv
// Packs consecutive MMIO writes into one wide word and hands it to a valid/ready consumer.
// One assembly buffer plus one output register lets software fill the next word during backpressure.
module ervp_mmio_wide_push #(
   parameter int BW_MMIO = 32,
   parameter int BW_WIDE_DATA = 32,
   parameter logic [BW_WIDE_DATA-1:0] DEFAULT_VALUE = '0,
   localparam int NUM_WORDS = (BW_WIDE_DATA + BW_MMIO - 1) / BW_MMIO,
   localparam int BW_INDEX = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    enable,
   input  logic                    mmio_we,
   input  logic [BW_MMIO-1:0]      mmio_wdata,
   input  logic                    mmio_re,
   output logic [BW_MMIO-1:0]      mmio_rdata,
   output logic                    wide_valid,
   input  logic                    wide_ready,
   output logic [BW_WIDE_DATA-1:0] wide_data,
   output logic [BW_INDEX-1:0]     word_index,
   output logic                    overflow
);

   localparam int BW_ASM = NUM_WORDS * BW_MMIO;
   localparam logic [BW_INDEX-1:0] LAST_SLOT = BW_INDEX'(NUM_WORDS - 1);

   typedef enum logic {FILL, FULL} state_t;

   state_t                  state, state_next;
   logic [BW_ASM-1:0]       asm_buf, asm_merged;
   logic [BW_INDEX-1:0]     word_index_next;
   logic [BW_WIDE_DATA-1:0] load_data;
   logic wr, out_free, accept, last_slot, asm_full;
   logic load, drop, asm_we;

   assign wr        = enable & mmio_we;
   assign accept    = wide_valid & wide_ready;
   assign out_free  = ~wide_valid | wide_ready;
   assign last_slot = (word_index == LAST_SLOT);
   assign asm_full  = (state == FULL);

   // Buffer contents as they would be with this cycle's write folded in.
   always_comb begin
      asm_merged = asm_buf;
      for (int i = 0; i < NUM_WORDS; i++)
         if (word_index == BW_INDEX'(i))
            asm_merged[i*BW_MMIO +: BW_MMIO] = mmio_wdata;
   end

   always_comb begin
      state_next      = state;
      word_index_next = word_index;
      load            = 1'b0;
      drop            = 1'b0;
      asm_we          = 1'b0;
      load_data       = asm_buf[BW_WIDE_DATA-1:0];
      case (state)
         FILL: begin
            if (wr) begin
               asm_we = 1'b1;
               if (last_slot) begin
                  word_index_next = '0;
                  if (out_free) begin
                     load      = 1'b1;
                     load_data = asm_merged[BW_WIDE_DATA-1:0];
                  end else begin
                     state_next = FULL;
                  end
               end else begin
                  word_index_next = word_index + BW_INDEX'(1);
               end
            end
         end
         FULL: begin
            // Writes stay dropped even in the cycle the held word drains.
            drop = wr;
            if (out_free) begin
               load       = 1'b1;
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state      <= FILL;
         word_index <= '0;
         asm_buf    <= BW_ASM'(DEFAULT_VALUE);
         wide_valid <= 1'b0;
         wide_data  <= DEFAULT_VALUE;
         overflow   <= 1'b0;
      end else begin
         state      <= state_next;
         word_index <= word_index_next;
         if (asm_we)
            asm_buf <= asm_merged;
         if (load) begin
            wide_valid <= 1'b1;
            wide_data  <= load_data;
         end else if (accept) begin
            wide_valid <= 1'b0;
         end
         if (drop)
            overflow <= 1'b1;
         else if (enable && mmio_re)
            overflow <= 1'b0;
      end
   end

   always_comb begin
      mmio_rdata                = '0;
      mmio_rdata[0]             = wide_valid;
      mmio_rdata[1]             = asm_full;
      mmio_rdata[2]             = overflow;
      mmio_rdata[3 +: BW_INDEX] = word_index;
   end

endmodule
